ps2_voice_allocator: RTL and testbench

Consumes the PS/2 keyboard receiver's scan-code stream and assigns keys to synthesizer voices. Owns the receiver's `read` acknowledge handshake and decodes make, break (F0) and extended (E0) sequences. Maps 13 keys to one chromatic octave and allocates them across 4 voices, with oldest-voice stealing. Sits between the keyboard receiver and the tone generators.

---
 rtl/ps2_voice_allocator_if.sv | 27 ++
 rtl/ps2_voice_allocator.sv | 169 ++++++++++++++++
 tb/tb_ps2_voice_allocator.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_voice_allocator_if.sv
// PS/2 receiver handshake bundle: byte-ready flag, byte, and the acknowledge pulse.
// Latency: none, wires only.
// Backpressure: the receiver holds scan_ready/scan_code until it sees read.
//
// Signals:
//   scan_ready - receiver has a byte (held until acknowledged)
//   scan_code  - received byte, valid while scan_ready=1
//   read       - one-cycle acknowledge back to the receiver
interface ps2_voice_allocator_if;
    logic       scan_ready;
    logic [7:0] scan_code;
    logic       read;

    // Receiver side drives the byte and consumes the acknowledge.
    modport master (
        output scan_ready,
        output scan_code,
        input  read
    );

    // Allocator side consumes the byte and drives the acknowledge.
    modport slave (
        input  scan_ready,
        input  scan_code,
        output read
    );
endinterface

// File: rtl/ps2_voice_allocator.sv
// Decodes PS/2 make/break/extended scan codes and assigns 13 keys to 4 voices with oldest-voice stealing.
// Latency: read one cycle after scan_ready is seen; voice outputs, gate_on and steal visible one cycle after read.
// Backpressure: one byte per handshake; waits for scan_ready to drop before accepting the next byte (>= 3 cycles/byte).
//
// Ports:
//   clock, reset   - 50 MHz clock, synchronous active-low reset
//   kbd            - receiver handshake (scan_ready, scan_code in; read out)
//   voice_active   - bit i set while voice i holds a note
//   voice_note     - note of voice i on bits [4i+3:4i]; keeps its value when the voice goes idle
//   gate_on        - one-cycle pulse on the voice that was (re)triggered
//   steal          - one-cycle pulse when an allocation evicted an active voice
module ps2_voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    ps2_voice_allocator_if.slave         kbd,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES-1:0]        gate_on,
    output logic                         steal
);
    localparam int VIDX_W = $clog2(NUM_VOICES);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ACK      = 2'd1;
    localparam logic [1:0] WAIT_LOW = 2'd2;

    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;

    logic [1:0]        state;
    logic [7:0]        byte_q;
    logic              brk;
    logic              ext;
    logic [1:0]        age [NUM_VOICES];

    logic              key_hit;
    logic [3:0]        key_raw;
    logic [NOTE_W-1:0] key_note;
    logic [NUM_VOICES-1:0] held;
    logic              free_vld;
    logic [VIDX_W-1:0] free_idx;
    logic [VIDX_W-1:0] oldest_idx;
    logic [1:0]        oldest_age;
    logic [VIDX_W-1:0] alloc_idx;

    // The acknowledge is simply "we are in the ACK state": exactly one cycle per byte.
    assign kbd.read = (state == ACK);

    // One chromatic octave on the home/upper rows.
    always_comb begin
        key_hit = 1'b1;
        key_raw = 4'd0;
        case (byte_q)
            8'h1C:   key_raw = 4'd0;
            8'h1D:   key_raw = 4'd1;
            8'h1B:   key_raw = 4'd2;
            8'h24:   key_raw = 4'd3;
            8'h23:   key_raw = 4'd4;
            8'h2B:   key_raw = 4'd5;
            8'h2C:   key_raw = 4'd6;
            8'h34:   key_raw = 4'd7;
            8'h35:   key_raw = 4'd8;
            8'h33:   key_raw = 4'd9;
            8'h3C:   key_raw = 4'd10;
            8'h3B:   key_raw = 4'd11;
            8'h42:   key_raw = 4'd12;
            default: key_hit = 1'b0;
        endcase
        key_note = NOTE_W'(key_raw);
    end

    // Voices currently sounding the decoded note (release target / repeat filter).
    always_comb begin
        held = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            held[i] = voice_active[i] && (voice_note[i*NOTE_W +: NOTE_W] == key_note);
        end
    end

    // Lowest-index idle voice; scanning downward leaves the lowest match last.
    always_comb begin
        free_vld = ~&voice_active;
        free_idx = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (!voice_active[i]) begin
                free_idx = VIDX_W'(i);
            end
        end
    end

    // Oldest voice; strict compare keeps the lowest index on ties.
    always_comb begin
        oldest_idx = '0;
        oldest_age = age[0];
        for (int i = 1; i < NUM_VOICES; i++) begin
            if (age[i] > oldest_age) begin
                oldest_idx = VIDX_W'(i);
                oldest_age = age[i];
            end
        end
        alloc_idx = free_vld ? free_idx : oldest_idx;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            byte_q       <= '0;
            brk          <= 1'b0;
            ext          <= 1'b0;
            voice_active <= '0;
            voice_note   <= '0;
            gate_on      <= '0;
            steal        <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                age[i] <= 2'd0;
            end
        end else begin
            gate_on <= '0;
            steal   <= 1'b0;
            case (state)
                IDLE: begin
                    if (kbd.scan_ready) begin
                        byte_q <= kbd.scan_code;
                        state  <= ACK;
                    end
                end
                ACK: begin
                    state <= WAIT_LOW;
                    if (byte_q == CODE_BREAK) begin
                        brk <= 1'b1;
                    end else if (byte_q == CODE_EXT) begin
                        ext <= 1'b1;
                    end else begin
                        // Any terminal byte ends the sequence, acted on or not.
                        brk <= 1'b0;
                        ext <= 1'b0;
                        if (!ext && key_hit) begin
                            if (brk) begin
                                voice_active <= voice_active & ~held;
                            end else if (held == '0) begin
                                voice_active[alloc_idx]                   <= 1'b1;
                                voice_note[alloc_idx*NOTE_W +: NOTE_W]    <= key_note;
                                gate_on[alloc_idx]                        <= 1'b1;
                                steal                                     <= ~free_vld;
                                // Ages are relative to the voices active before this press.
                                for (int i = 0; i < NUM_VOICES; i++) begin
                                    if (VIDX_W'(i) == alloc_idx) begin
                                        age[i] <= 2'd0;
                                    end else if (voice_active[i] && age[i] != 2'd3) begin
                                        age[i] <= age[i] + 2'd1;
                                    end
                                end
                            end
                        end
                    end
                end
                WAIT_LOW: begin
                    if (!kbd.scan_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_voice_allocator.sv
// Directed bench for ps2_voice_allocator: plays byte sequences through the receiver handshake
// and compares voice state against hand-computed expectations.
module tb_ps2_voice_allocator;
    logic        clock;
    logic        reset;
    logic [3:0]  voice_active;
    logic [15:0] voice_note;
    logic [3:0]  gate_on;
    logic        steal;

    ps2_voice_allocator_if kbd ();

    ps2_voice_allocator #(
        .NUM_VOICES (4),
        .NOTE_W     (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .kbd          (kbd.slave),
        .voice_active (voice_active),
        .voice_note   (voice_note),
        .gate_on      (gate_on),
        .steal        (steal)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Results of the most recent send_byte.
    int         read_lat;
    int         n_reads;
    logic [3:0] last_gate;
    logic       last_steal;
    logic [3:0] next_gate;
    int         gate_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one byte, wait (bounded) for the acknowledge, hold scan_ready
    // for 'hold' extra cycles, then drop it and let the FSM return to IDLE.
    task automatic send_byte(input logic [7:0] code, input int hold);
        int waited;
        waited     = 0;
        n_reads    = 0;
        @(negedge clock);
        kbd.scan_ready = 1'b1;
        kbd.scan_code  = code;
        while (!kbd.read && waited < 10) begin
            @(negedge clock);
            waited++;
        end
        check("read_seen", {31'd0, kbd.read}, 32'd1);
        read_lat = waited;
        n_reads  = kbd.read ? 1 : 0;
        @(negedge clock);
        last_gate  = gate_on;
        last_steal = steal;
        n_reads   += kbd.read ? 1 : 0;
        if (gate_on != 4'b0000) gate_count++;
        @(negedge clock);
        next_gate = gate_on;
        n_reads  += kbd.read ? 1 : 0;
        for (int k = 0; k < hold; k++) begin
            @(negedge clock);
            n_reads += kbd.read ? 1 : 0;
        end
        kbd.scan_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            n_reads += kbd.read ? 1 : 0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_read"},   {31'd0, kbd.read},    32'd0);
        check({tag, "_active"}, {28'd0, voice_active}, 32'd0);
        check({tag, "_note"},   {16'd0, voice_note},   32'd0);
        check({tag, "_gate"},   {28'd0, gate_on},      32'd0);
        check({tag, "_steal"},  {31'd0, steal},        32'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b0;
        kbd.scan_ready = 1'b0;
        kbd.scan_code  = 8'h00;
        gate_count     = 0;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b1;

        // Single press, scan_ready held long: exactly one acknowledge.
        send_byte(8'h1C, 5);
        check("press_a_read_lat",  read_lat,              32'd1);
        check("press_a_read_once", n_reads,               32'd1);
        check("press_a_active",    {28'd0, voice_active}, 32'h1);
        check("press_a_note",      {28'd0, voice_note[3:0]}, 32'h0);
        check("press_a_gate",      {28'd0, last_gate},    32'h1);
        check("press_a_gate_once", {28'd0, next_gate},    32'h0);
        check("press_a_steal",     {31'd0, last_steal},   32'h0);

        // Two voices, then release the first.
        do_reset();
        send_byte(8'h1C, 0);
        send_byte(8'h1D, 0);
        check("aw_active", {28'd0, voice_active}, 32'h3);
        check("aw_notes",  {24'd0, voice_note[7:0]}, 32'h10);
        check("aw_gate",   {28'd0, last_gate},    32'h2);
        send_byte(8'hF0, 0);
        send_byte(8'h1C, 0);
        check("rel_a_active", {28'd0, voice_active}, 32'h2);
        check("rel_a_note1",  {28'd0, voice_note[7:4]}, 32'h1);
        check("rel_a_note0",  {28'd0, voice_note[3:0]}, 32'h0);
        check("rel_a_gate",   {28'd0, last_gate},    32'h0);

        // Typematic repeat.
        do_reset();
        gate_count = 0;
        for (int r = 0; r < 5; r++) send_byte(8'h1C, 1);
        check("repeat_gates",  gate_count,             32'd1);
        check("repeat_active", {28'd0, voice_active}, 32'h1);

        // Fill all voices, then steal the oldest twice.
        do_reset();
        send_byte(8'h1C, 0);
        send_byte(8'h1D, 0);
        send_byte(8'h1B, 0);
        send_byte(8'h24, 0);
        check("fill_active", {28'd0, voice_active}, 32'hF);
        check("fill_steal",  {31'd0, last_steal},   32'h0);
        send_byte(8'h23, 0);
        check("steal0_steal", {31'd0, last_steal},   32'h1);
        check("steal0_gate",  {28'd0, last_gate},    32'h1);
        check("steal0_notes", {16'd0, voice_note},   32'h3214);
        check("steal0_active", {28'd0, voice_active}, 32'hF);
        send_byte(8'h2B, 0);
        check("steal1_steal", {31'd0, last_steal},   32'h1);
        check("steal1_gate",  {28'd0, last_gate},    32'h2);
        check("steal1_notes", {16'd0, voice_note},   32'h3254);
        send_byte(8'hF0, 0);
        send_byte(8'h23, 0);
        check("rel_e_active", {28'd0, voice_active}, 32'hE);
        send_byte(8'h2C, 0);
        check("refill_gate",  {28'd0, last_gate},    32'h1);
        check("refill_steal", {31'd0, last_steal},   32'h0);
        check("refill_notes", {16'd0, voice_note},   32'h3256);

        // Extended prefix swallows the next byte, then clears.
        do_reset();
        send_byte(8'hE0, 0);
        send_byte(8'h1C, 0);
        check("ext_active", {28'd0, voice_active}, 32'h0);
        check("ext_gate",   {28'd0, last_gate},    32'h0);
        send_byte(8'h1C, 0);
        check("post_ext_active", {28'd0, voice_active}, 32'h1);
        check("post_ext_gate",   {28'd0, last_gate},    32'h1);

        // Reset after a pending break prefix discards it.
        do_reset();
        send_byte(8'h1D, 0);
        check("pre_rst_active", {28'd0, voice_active}, 32'h1);
        send_byte(8'hF0, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_all_zero("mid_rst");
        reset = 1'b1;
        @(negedge clock);
        check_all_zero("post_rst");
        send_byte(8'h1C, 0);
        check("rst_brk_active", {28'd0, voice_active},   32'h1);
        check("rst_brk_note",   {28'd0, voice_note[3:0]}, 32'h0);
        check("rst_brk_gate",   {28'd0, last_gate},      32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
